// File: rtl/onehot_pkg.sv
// Shared types, constants and the one-hot helper for the sequenced decoder.
package onehot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } dec_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest select word the helper can build (2**6 lines for CODE_W = 6).
  localparam int MAX_OUT_W = 64;

  // Active-high one-hot vector: bit idx set when idx < width, all zero otherwise.
  function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned idx,
                                                  input int unsigned width);
    logic [MAX_OUT_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_OUT_W; i++) begin
      if ((i < width) && (i == idx)) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/onehot_decoder_seq_prescaler.sv
// Divide-by-DIV tick generator that paces SCAN-mode index advances.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // Counter is wide enough to hold DIV itself, so DIV-1 never aliases.
  localparam int             CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Tick is asserted on the last count of each period while counting is enabled.
  assign tick = en && (r_cnt == LAST);

  // Count 0..DIV-1 while enabled; clear forces the count back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : (r_cnt + CW'(1));
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot select generator with DIRECT (handshake) and SCAN (auto-step) modes.
module onehot_decoder_seq
  import onehot_pkg::*;
#(
  parameter int CODE_W     = 3,
  parameter int OUT_W      = 8,
  parameter int SCAN_DIV   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              mode_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic              code_valid_i,
  output logic              code_ready_o,
  output logic [OUT_W-1:0]  q_o,
  output logic [CODE_W-1:0] idx_o,
  output logic              step_o,
  output logic              err_o
);

  // Index compare/increment carry one extra bit so OUT_W itself is representable.
  localparam int             IW       = CODE_W + 1;
  localparam logic [IW-1:0]  OUT_W_X  = IW'(OUT_W);
  localparam logic [OUT_W-1:0] POL_MASK = {OUT_W{ACTIVE_LOW}};

  dec_state_t           r_state;
  logic [CODE_W-1:0]    r_idx;
  logic                 r_err;
  logic                 r_step;
  logic [OUT_W-1:0]     r_q;

  dec_state_t           w_state_nxt;
  logic [CODE_W-1:0]    w_idx_nxt;
  logic                 w_err_nxt;
  logic                 w_code_oob;
  logic [IW-1:0]        w_idx_inc;
  logic [CODE_W-1:0]    w_idx_wrap;
  logic                 w_pre_en;
  logic                 w_pre_clr;
  logic                 w_tick;
  logic [MAX_OUT_W-1:0] w_hot_full;
  logic [OUT_W-1:0]     w_hot;
  logic [OUT_W-1:0]     w_q_nxt;

  // Prescaler only runs while actively scanning; anything else holds it at zero.
  assign w_pre_en  = (r_state == SCAN) && en_i;
  assign w_pre_clr = !w_pre_en;

  tick_prescaler #(
    .DIV (SCAN_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_pre_clr),
    .en   (w_pre_en),
    .tick (w_tick)
  );

  // Range check and wrap-at-OUT_W increment, done one bit wider than the index.
  assign w_code_oob = ({1'b0, code_i} >= OUT_W_X);
  assign w_idx_inc  = {1'b0, r_idx} + IW'(1);
  assign w_idx_wrap = (w_idx_inc >= OUT_W_X) ? '0 : w_idx_inc[CODE_W-1:0];

  // Ready depends only on the current state, so a code is never accepted in IDLE or SCAN.
  assign code_ready_o = (r_state == DIRECT);

  // Next state, index and error flag; mode_i is only looked at when leaving IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE: begin
        if (en_i) begin
          if (mode_i == MODE_SCAN) begin
            w_state_nxt = SCAN;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = DIRECT;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DIRECT: begin
        if (!en_i) begin
          w_state_nxt = IDLE;
        end else if (code_valid_i) begin
          if (w_code_oob) begin
            w_err_nxt = 1'b1;
          end else begin
            w_idx_nxt = code_i;
          end
        end else begin
          w_idx_nxt = r_idx;
        end
      end
      SCAN: begin
        if (!en_i) begin
          w_state_nxt = IDLE;
        end else if (w_tick) begin
          w_idx_nxt = w_idx_wrap;
        end else begin
          w_idx_nxt = r_idx;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Select word is built from the next index so q_o always agrees with idx_o.
  assign w_hot_full = onehot(32'(w_idx_nxt), 32'(OUT_W));
  assign w_hot      = w_hot_full[OUT_W-1:0];
  assign w_q_nxt    = ((w_state_nxt == IDLE) ? '0 : w_hot) ^ POL_MASK;

  generate
    if (OUT_W < MAX_OUT_W) begin : g_unused_hot
      logic w_unused_hot;
      assign w_unused_hot = |w_hot_full[MAX_OUT_W-1:OUT_W];
    end
  endgenerate

  // State and all outputs are registered together; reset wins over every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_step  <= 1'b0;
      r_q     <= POL_MASK;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_err   <= w_err_nxt;
      r_step  <= w_tick;
      r_q     <= w_q_nxt;
    end
  end

  assign q_o    = r_q;
  assign idx_o  = r_idx;
  assign step_o = r_step;
  assign err_o  = r_err;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench: three parameterisations driven in lockstep against a behavioural model.
module tb_onehot_decoder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en_i = 1'b0;
  logic       mode_i = 1'b0;
  logic       code_valid_i = 1'b0;
  logic [2:0] code_i = 3'd0;

  logic       rdy_a, step_a, err_a;
  logic [7:0] q_a;
  logic [2:0] idx_a;
  logic       rdy_b, step_b, err_b;
  logic [5:0] q_b;
  logic [2:0] idx_b;
  logic       rdy_c, step_c, err_c;
  logic [3:0] q_c;
  logic [1:0] idx_c;

  onehot_decoder_seq #(.CODE_W(3), .OUT_W(8), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i), .code_i(code_i),
    .code_valid_i(code_valid_i), .code_ready_o(rdy_a), .q_o(q_a), .idx_o(idx_a),
    .step_o(step_a), .err_o(err_a));

  onehot_decoder_seq #(.CODE_W(3), .OUT_W(6), .SCAN_DIV(4), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i), .code_i(code_i),
    .code_valid_i(code_valid_i), .code_ready_o(rdy_b), .q_o(q_b), .idx_o(idx_b),
    .step_o(step_b), .err_o(err_b));

  onehot_decoder_seq #(.CODE_W(2), .OUT_W(4), .SCAN_DIV(1), .ACTIVE_LOW(1'b0)) dut_c (
    .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i), .code_i(code_i[1:0]),
    .code_valid_i(code_valid_i), .code_ready_o(rdy_c), .q_o(q_c), .idx_o(idx_c),
    .step_o(step_c), .err_o(err_c));

  int n_cmp = 0;
  int n_bad = 0;

  // Configuration of each instance, indexed 0..2 = a, b, c.
  int cfg_out_w [3] = '{8, 6, 4};
  int cfg_div   [3] = '{4, 4, 1};
  int cfg_al    [3] = '{0, 1, 0};
  int cfg_cw    [3] = '{3, 3, 2};

  // Model: activity 0 = off, 1 = loading codes, 2 = scanning; sc = cycles since scan start.
  int m_act [3] = '{0, 0, 0};
  int m_idx [3] = '{0, 0, 0};
  int m_sc  [3] = '{0, 0, 0};
  int m_err [3] = '{0, 0, 0};
  int m_step[3] = '{0, 0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int c;
      c = int'(code_i) & ((1 << cfg_cw[i]) - 1);
      if (rst === 1'b1) begin
        m_act[i] = 0; m_idx[i] = 0; m_sc[i] = 0; m_err[i] = 0; m_step[i] = 0;
      end else if (m_act[i] == 0) begin
        m_step[i] = 0;
        if (en_i === 1'b1) begin
          if (mode_i === 1'b1) begin
            m_act[i] = 2; m_idx[i] = 0; m_sc[i] = 0;
          end else begin
            m_act[i] = 1;
          end
        end
      end else if (m_act[i] == 1) begin
        m_step[i] = 0;
        if (en_i !== 1'b1) m_act[i] = 0;
        else if (code_valid_i === 1'b1) begin
          if (c >= cfg_out_w[i]) m_err[i] = 1;
          else m_idx[i] = c;
        end
      end else begin
        if (en_i !== 1'b1) begin
          m_act[i] = 0; m_step[i] = 0;
        end else begin
          m_sc[i]++;
          m_step[i] = (m_sc[i] % cfg_div[i] == 0) ? 1 : 0;
          m_idx[i]  = (m_sc[i] / cfg_div[i]) % cfg_out_w[i];
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic [63:0] aq, ai, ar, ae, as_, hot, mask;
      case (i)
        0: begin aq = 64'(q_a); ai = 64'(idx_a); ar = 64'(rdy_a); ae = 64'(err_a); as_ = 64'(step_a); end
        1: begin aq = 64'(q_b); ai = 64'(idx_b); ar = 64'(rdy_b); ae = 64'(err_b); as_ = 64'(step_b); end
        default: begin aq = 64'(q_c); ai = 64'(idx_c); ar = 64'(rdy_c); ae = 64'(err_c); as_ = 64'(step_c); end
      endcase
      mask = (64'd1 << cfg_out_w[i]) - 64'd1;
      hot  = (m_act[i] != 0) ? (64'd1 << m_idx[i]) : 64'd0;
      if (cfg_al[i] != 0) hot = ~hot & mask;
      check($sformatf("model_q[%0d]", i), aq, hot);
      check($sformatf("model_idx[%0d]", i), ai, 64'(m_idx[i]));
      check($sformatf("model_ready[%0d]", i), ar, (m_act[i] == 1) ? 64'd1 : 64'd0);
      check($sformatf("model_err[%0d]", i), ae, 64'(m_err[i]));
      check($sformatf("model_step[%0d]", i), as_, 64'(m_step[i]));
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic m, input logic v, input logic [2:0] c);
    rst = r; en_i = e; mode_i = m; code_valid_i = v; code_i = c;
  endtask

  // One clock: model update, active edge, then sample 1 time unit later.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  typedef struct {
    logic       r, e, m, v;
    logic [2:0] c;
    logic [7:0] q;
    logic [2:0] idx;
    logic       rdy, err, step;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic r, input logic e, input logic m, input logic v,
                              input logic [2:0] c, input logic [7:0] q, input logic [2:0] idx,
                              input logic rdy, input logic err, input logic step);
    vec_t t;
    t.r = r; t.e = e; t.m = m; t.v = v; t.c = c;
    t.q = q; t.idx = idx; t.rdy = rdy; t.err = err; t.step = step;
    return t;
  endfunction

  initial begin
    // Reset, DIRECT codes 0..7 back to back, then a code ignored while disabling.
    tv.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
    tv.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
    tv.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0));
    for (int c = 0; c < 8; c++) begin
      logic [7:0] qv;
      qv = 8'd1 << c;
      tv.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 3'(c), qv, 3'(c), 1'b1, 1'b0, 1'b0));
    end
    tv.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 3'd7, 1'b1, 1'b0, 1'b0));
    tv.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0));

    #1;
    for (int k = 0; k < tv.size(); k++) begin
      drive(tv[k].r, tv[k].e, tv[k].m, tv[k].v, tv[k].c);
      cycle();
      check("tbl_q", 64'(q_a), 64'(tv[k].q));
      check("tbl_idx", 64'(idx_a), 64'(tv[k].idx));
      check("tbl_ready", 64'(rdy_a), 64'(tv[k].rdy));
      check("tbl_err", 64'(err_a), 64'(tv[k].err));
      check("tbl_step", 64'(step_a), 64'(tv[k].step));
      if (k < 2) check("rst_q_active_low", 64'(q_b), 64'h3F);
    end

    // Out-of-range code on the 6-line instance: index kept, sticky error until reset.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0); cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0); cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd3); cycle();
    check("oob_q_before", 64'(q_b), 64'h37);
    check("oob_err_before", 64'(err_b), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd6); cycle();
    check("oob_q_held", 64'(q_b), 64'h37);
    check("oob_idx_held", 64'(idx_b), 64'd3);
    check("oob_err_set", 64'(err_b), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0); cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0); cycle();
    check("oob_err_sticky", 64'(err_b), 64'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0); cycle();
    check("oob_err_rst", 64'(err_b), 64'd0);

    // SCAN wrap at OUT_W=6 with 4 cycles per step; SCAN_DIV=1 instance steps every cycle.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0); cycle();
    check("scan_entry_idx", 64'(idx_b), 64'd0);
    for (int k = 1; k <= 28; k++) begin
      cycle();
      check("scan_idx", 64'(idx_b), 64'((k / 4) % 6));
      check("scan_step", 64'(step_b), (k % 4 == 0) ? 64'd1 : 64'd0);
      check("scan_div1_step", 64'(step_c), 64'd1);
    end

    // Drop enable at idx 3, re-enter SCAN, then reset during DIRECT with a valid code.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0); cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0); cycle();
    for (int k = 0; k < 12; k++) cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0); cycle();
    check("drop_idx", 64'(idx_b), 64'd3);
    check("drop_q", 64'(q_b), 64'h3F);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0); cycle();
    check("reenter_idx", 64'(idx_b), 64'd0);
    check("reenter_q", 64'(q_b), 64'h3E);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0); cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0); cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd5); cycle();
    check("rst_direct_idx", 64'(idx_a), 64'd0);
    check("rst_direct_q", 64'(q_a), 64'h00);
    check("rst_direct_ready", 64'(rdy_a), 64'd0);

    // mode_i toggled while in DIRECT must not switch to SCAN.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0); cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("guard_ready", 64'(rdy_a), 64'd1);
      check("guard_step", 64'(step_a), 64'd0);
    end

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      drive(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Parametrised, registered successor to the team's 3-to-8 combinational one-hot decoder.
- Converts a CODE_W-bit index into an OUT_W-bit one-hot select word, with output polarity set by a parameter.
- Two modes: DIRECT loads an index through a valid/ready handshake; SCAN auto-increments the index with a prescaled tick and wraps, for display digit or row multiplexing.
- Sits between control logic and multiplexed outputs such as 7-segment anodes or LED rows.

Parameters:
- CODE_W, 3, index width; legal range 1..6.
- OUT_W, 8, number of select lines; must satisfy 1 <= OUT_W <= 2**CODE_W.
- SCAN_DIV, 4, clock cycles per SCAN step; must be >= 1.
- ACTIVE_LOW, 0, 1 inverts q_o so the selected line is 0 and all others are 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en_i  in  1  global enable; 0 forces the IDLE state.
- mode_i  in  1  0 = DIRECT, 1 = SCAN; sampled only in IDLE.
- code_i  in  CODE_W  requested index (DIRECT mode).
- code_valid_i  in  1  code_i is valid.
- code_ready_o  out  1  block accepts a code this cycle.
- q_o  out  OUT_W  registered one-hot select word (polarity per ACTIVE_LOW).
- idx_o  out  CODE_W  index currently driven on q_o.
- step_o  out  1  one-cycle pulse on each SCAN advance.
- err_o  out  1  sticky flag: an out-of-range code (code_i >= OUT_W) was accepted.

Behaviour:
- Reset, and every cycle with rst=1:
  - state = IDLE, idx_o = 0, step_o = 0, err_o = 0, code_ready_o = 0, prescaler = 0.
  - q_o = all-inactive: all 0s, or all 1s when ACTIVE_LOW=1.
  - rst overrides every other input.
- Active level of q_o: bit i is active when the state is DIRECT or SCAN and idx_o == i. All bits are inactive in IDLE.
- FSM, state IDLE:
  - Outputs inactive, code_ready_o = 0.
  - If en_i=1: go to DIRECT when mode_i=0, to SCAN when mode_i=1.
- FSM, state DIRECT:
  - code_ready_o = 1, driven combinationally from the state.
  - On code_valid_i & code_ready_o, code_i is registered into idx_o. q_o reflects it on the next edge, i.e. 1 cycle of latency from the accepting edge.
  - If the accepted code_i >= OUT_W: idx_o is left unchanged and err_o is set to 1.
  - en_i=0 returns to IDLE on the next edge; a code presented in that same cycle is ignored.
  - mode_i changes are ignored until the block passes through IDLE.
- FSM, state SCAN:
  - code_ready_o = 0.
  - Prescaler counts 0..SCAN_DIV-1. When it reaches SCAN_DIV-1:
    - prescaler returns to 0;
    - idx_o advances by 1, wrapping from OUT_W-1 to 0 (not at 2**CODE_W-1);
    - step_o = 1 for exactly that one cycle.
  - SCAN_DIV=1 advances every cycle, with step_o held high continuously.
  - Entering SCAN from IDLE: idx_o = 0 and prescaler = 0. The first step occurs SCAN_DIV cycles after entry.
  - en_i=0 returns to IDLE, clears the prescaler, and holds idx_o.
- err_o is cleared only by rst.
- idx_o holds its last value in IDLE.
- OUT_W = 2**CODE_W: out-of-range codes cannot occur and err_o stays 0.
- Arithmetic: the prescaler is $clog2(SCAN_DIV+1) bits wide. Index compare and increment are CODE_W+1 bits wide, so no overflow aliasing occurs.

Decomposition:
- Shared package onehot_pkg:
  - typedef enum logic [1:0] {IDLE, DIRECT, SCAN} dec_state_t;
  - localparam MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1.
  - function onehot(idx, width), returning the active-high one-hot vector.
- One sub-module, tick_prescaler (params DIV; ports clk, rst, clr, en, tick), generates the SCAN step pulse.
- Polarity inversion and the output register stay in the top module.

Test Plan:
1. Reset with ACTIVE_LOW=0: hold rst 2 cycles -> q_o=8'h00, idx_o=0, err_o=0, code_ready_o=0. With ACTIVE_LOW=1 -> q_o=8'hFF.
2. DIRECT: en_i=1, mode_i=0, send codes 0..7 on back-to-back valid cycles -> q_o=01,02,04,...,80, each one cycle after its accept; code_ready_o stays 1 throughout.
3. Out-of-range: OUT_W=6, CODE_W=3, accept code 3, then code 6 -> q_o stays 6'b001000, err_o=1 and remains 1 after en_i toggles; only rst clears it.
4. SCAN wrap: OUT_W=6, SCAN_DIV=4 -> idx_o sequence 0,1,2,3,4,5,0; each value lasts 4 cycles; step_o pulses every 4th cycle; no q_o bit above bit 5 is ever set.
5. Mid-operation events: in SCAN with idx_o=3, drop en_i -> next cycle IDLE, q_o inactive, idx_o=3. Re-enter SCAN -> idx_o=0. Assert rst during DIRECT with code_valid_i=1 -> code discarded, reset values apply.
6. Mode-change guard: in DIRECT, toggle mode_i to 1 without dropping en_i -> remains DIRECT, code_ready_o=1, no step_o pulses.
